fir_decim2_comp: RTL

CIC droop-compensation FIR with decimate-by-2. It sits directly downstream of the 4-stage CIC decimator and consumes its 24-bit output and single-cycle valid strobe. It uses one time-multiplexed multiplier-accumulator, a circular sample history and a runtime-loadable coefficient register file. Output is 24-bit, one valid pulse per two accepted input samples.

---
 rtl/fir_decim2_comp.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fir_decim2_comp.sv
// -----------------------------------------------------------------------------
// fir_decim2_comp
//   CIC droop-compensation FIR with decimate-by-2. One time-multiplexed
//   multiplier-accumulator walks NTAPS taps over a circular sample history on
//   every second accepted input sample, then rounds, saturates and emits one
//   output sample.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high
//   in_data    signed input sample (IW bits)
//   in_valid   one-cycle strobe, in_data accepted this cycle
//   coef_we    coefficient write enable
//   coef_addr  tap index k
//   coef_data  signed coefficient c[k] (CW bits)
//   out_data   signed filtered, decimated sample (OW bits), held between strobes
//   out_valid  one-cycle strobe qualifying out_data
//   busy       MAC pass in progress
//   overrun    sticky, a trigger arrived while busy
// -----------------------------------------------------------------------------
module fir_decim2_comp #(
  parameter int IW        = 24,
  parameter int OW        = 24,
  parameter int CW        = 18,
  parameter int NTAPS     = 32,
  parameter int ACC_W     = 48,
  parameter int OUT_SHIFT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IW-1:0]             in_data,
  input  logic                      in_valid,
  input  logic                      coef_we,
  input  logic [$clog2(NTAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]             coef_data,
  output logic [OW-1:0]             out_data,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int AW = $clog2(NTAPS);   // tap index width
  localparam int HW = AW + 1;          // history index width (depth 2*NTAPS)
  localparam int PW = IW + CW;         // full-precision product width

  localparam logic [AW:0] FILL_FULL = (AW+1)'(NTAPS);
  localparam logic signed [ACC_W-1:0] RND_HALF =
    {{(ACC_W-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MAC, FLUSH, ROUND, OUT} state_t;

  logic signed [IW-1:0]    hist [2*NTAPS];
  logic signed [CW-1:0]    coef [NTAPS];

  state_t                  state;
  logic [HW-1:0]           wr_ptr;
  logic [HW-1:0]           base;       // address of x[n] for the running pass
  logic [AW:0]             fill;       // samples received since reset, saturating
  logic [AW:0]             fill_snap;  // valid history depth for the running pass
  logic                    phase;
  logic [AW-1:0]           tap;
  logic signed [PW-1:0]    prod;
  logic                    prod_vld;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] shifted;
  logic [OW-1:0]           sat;

  logic [HW-1:0]           rd_addr;
  logic                    tap_live;
  logic                    trigger;

  // x[n-k] lives k slots behind the snapshot; wraps naturally in HW bits.
  // Reads of base-k never collide with the concurrent write at base+1+k
  // because their distance is always odd.
  assign rd_addr  = base - HW'(tap);
  // Taps older than the first sample since reset contribute zero.
  assign tap_live = ({1'b0, tap} < fill_snap);
  assign trigger  = in_valid && phase && !busy;

  // NOTE: storage arrays carry no reset; their contents are qualified by
  // fill_snap, so clearing them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (in_valid) hist[wr_ptr] <= $signed(in_data);
    if (coef_we)  coef[coef_addr] <= $signed(coef_data);
  end

  always_comb begin
    shifted = rnd >>> OUT_SHIFT;
    if (shifted > OUT_MAX)
      sat = OUT_MAX[OW-1:0];
    else if (shifted < OUT_MIN)
      sat = OUT_MIN[OW-1:0];
    else
      sat = shifted[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      base      <= '0;
      fill      <= '0;
      fill_snap <= '0;
      phase     <= 1'b0;
      tap       <= '0;
      prod      <= '0;
      prod_vld  <= 1'b0;
      acc       <= '0;
      rnd       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      // Sample intake runs independently of the MAC pass.
      if (in_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        phase  <= ~phase;
        if (fill != FILL_FULL) fill <= fill + 1'b1;
        if (phase && busy) overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (trigger) begin
            state     <= MAC;
            busy      <= 1'b1;
            base      <= wr_ptr;
            // The triggering sample itself is part of the history.
            fill_snap <= (fill == FILL_FULL) ? fill : fill + 1'b1;
            tap       <= '0;
            acc       <= '0;
            prod_vld  <= 1'b0;
          end else begin
            // busy stays up through the out_valid cycle.
            busy <= 1'b0;
          end
        end
        MAC: begin
          prod     <= tap_live ? PW'(coef[tap]) * PW'(hist[rd_addr]) : '0;
          prod_vld <= 1'b1;
          if (prod_vld) acc <= acc + ACC_W'(prod);
          tap <= tap + 1'b1;
          if (tap == AW'(NTAPS - 1)) state <= FLUSH;
        end
        FLUSH: begin
          // Accumulate the last registered product.
          acc      <= acc + ACC_W'(prod);
          prod_vld <= 1'b0;
          state    <= ROUND;
        end
        ROUND: begin
          rnd   <= acc + RND_HALF;
          state <= OUT;
        end
        OUT: begin
          out_data  <= sat;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
